// File: rtl/cordic_pkg.sv
// Shared constants, state encodings and format helpers for the CORDIC sin/cos engine.
package cordic_pkg;

    localparam int unsigned N    = 32;
    localparam int unsigned Q    = 16;
    localparam int unsigned ITER = 16;

    // Q16 angle constants and the CORDIC gain compensation factor
    localparam logic [N-1:0] PI_2  = 32'h0001_921F;
    localparam logic [N-1:0] PI    = 32'h0003_243F;
    localparam logic [N-1:0] PI3_2 = 32'h0004_B65F;
    localparam logic [N-1:0] PI2   = 32'h0006_487F;
    localparam logic [N-1:0] K     = 32'h0000_9B75;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StIter    = 3'd2;
    localparam logic [2:0] StCorrect = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    // Sign-magnitude to two's complement
    function automatic logic [N-1:0] sm_to_tc(input logic [N-1:0] v);
        logic [N-1:0] mag;
        mag = {1'b0, v[N-2:0]};
        return v[N-1] ? -mag : mag;
    endfunction

    // Two's complement to sign-magnitude; a zero magnitude always gets sign 0
    function automatic logic [N-1:0] tc_to_sm(input logic [N-1:0] v);
        logic [N-1:0] mag;
        mag = v[N-1] ? -v : v;
        if (mag[N-2:0] == '0) begin
            return '0;
        end
        return {v[N-1], mag[N-2:0]};
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// atan(2^-i) lookup in Q16, i = 0..15.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [3:0]   idx,
    output logic [N-1:0] atan_val
);

    // Combinational table lookup
    always_comb begin
        atan_val = '0;
        case (idx)
            4'd0:  atan_val = 32'h0000_C910;
            4'd1:  atan_val = 32'h0000_76B2;
            4'd2:  atan_val = 32'h0000_3EB7;
            4'd3:  atan_val = 32'h0000_1FD6;
            4'd4:  atan_val = 32'h0000_0FFB;
            4'd5:  atan_val = 32'h0000_07FF;
            4'd6:  atan_val = 32'h0000_0400;
            4'd7:  atan_val = 32'h0000_0200;
            4'd8:  atan_val = 32'h0000_0100;
            4'd9:  atan_val = 32'h0000_0080;
            4'd10: atan_val = 32'h0000_0040;
            4'd11: atan_val = 32'h0000_0020;
            4'd12: atan_val = 32'h0000_0010;
            4'd13: atan_val = 32'h0000_0008;
            4'd14: atan_val = 32'h0000_0004;
            default: atan_val = 32'h0000_0002;
        endcase
    end

endmodule

// File: rtl/cordic_sincos_iter.sv
// Iterative rotation-mode CORDIC: sign-magnitude Q15.16 angle in [0, 2pi) -> cos/sin.
// Optional macro CORDIC_RANGE_CHK_EN adds the range_err output and forces
// cos=1, sin=0 for |angle| >= 2pi.
module cordic_sincos_iter
    import cordic_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         startcordic,
    input  logic [N-1:0] angle,
    output logic [N-1:0] cos_out,
    output logic [N-1:0] sin_out,
`ifdef CORDIC_RANGE_CHK_EN
    output logic         range_err,
`endif
    output logic         donecordic
);

    logic [2:0]          state_q;
    logic [3:0]          cnt_q;
    logic [N-1:0]        angle_q;
    logic signed [N-1:0] x_q, y_q, z_q;
    logic                neg_q, sneg_q;

    logic [N-1:0]        m;
    logic [N-1:0]        phi;
    logic                neg_fold;
    logic [N-1:0]        atan_val;
    logic signed [N-1:0] x_sh, y_sh;
    logic signed [N-1:0] x_nxt, y_nxt, z_nxt;
    logic [N-1:0]        cos_sm, sin_sm;

    cordic_atan_rom u_atan_rom (
        .idx      (cnt_q),
        .atan_val (atan_val)
    );

    // Quadrant fold of |angle| into [-pi/2, pi/2) with a cos-negate flag
    always_comb begin
        m        = {1'b0, angle_q[N-2:0]};
        phi      = m;
        neg_fold = 1'b0;
        if (m < PI_2) begin
            phi      = m;
            neg_fold = 1'b0;
        end else if (m < PI3_2) begin
            phi      = m - PI;
            neg_fold = 1'b1;
        end else begin
            phi      = m - PI2;
            neg_fold = 1'b0;
        end
    end

    // One micro-rotation; direction follows the sign of the residual angle
    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        if (!z_q[N-1]) begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - $signed(atan_val);
        end else begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + $signed(atan_val);
        end
    end

    // Undo the fold and the input sign, then convert back to sign-magnitude
    always_comb begin
        cos_sm = tc_to_sm(neg_q ? -x_q : x_q);
        sin_sm = tc_to_sm((neg_q ^ sneg_q) ? -y_q : y_q);
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            angle_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            neg_q      <= 1'b0;
            sneg_q     <= 1'b0;
            cos_out    <= '0;
            sin_out    <= '0;
            donecordic <= 1'b0;
`ifdef CORDIC_RANGE_CHK_EN
            range_err  <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    donecordic <= 1'b0;
                    if (startcordic) begin
                        angle_q <= angle;
`ifdef CORDIC_RANGE_CHK_EN
                        range_err <= 1'b0;
`endif
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    x_q     <= K;
                    y_q     <= '0;
                    z_q     <= phi;
                    neg_q   <= neg_fold;
                    sneg_q  <= angle_q[N-1];
                    cnt_q   <= '0;
`ifdef CORDIC_RANGE_CHK_EN
                    range_err <= (m >= PI2);
`endif
                    state_q <= StIter;
                end
                StIter: begin
                    x_q <= x_nxt;
                    y_q <= y_nxt;
                    z_q <= z_nxt;
                    if (cnt_q == 4'(ITER - 1)) begin
                        state_q <= StCorrect;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StCorrect: begin
`ifdef CORDIC_RANGE_CHK_EN
                    if (range_err) begin
                        cos_out <= 32'h0001_0000;
                        sin_out <= '0;
                    end else begin
                        cos_out <= cos_sm;
                        sin_out <= sin_sm;
                    end
`else
                    cos_out <= cos_sm;
                    sin_out <= sin_sm;
`endif
                    state_q <= StDone;
                end
                StDone: begin
                    donecordic <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Self-checking bench for cordic_sincos_iter: directed vector table, reset and
// ignored-start sequences, and random angles checked against real-valued cos/sin.
module tb_cordic_sincos_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        startcordic;
    logic [31:0] angle;
    logic [31:0] cos_out;
    logic [31:0] sin_out;
    logic        donecordic;
`ifdef CORDIC_RANGE_CHK_EN
    logic        range_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cordic_sincos_iter dut (
        .clk         (clk),
        .rst         (rst),
        .startcordic (startcordic),
        .angle       (angle),
        .cos_out     (cos_out),
        .sin_out     (sin_out),
`ifdef CORDIC_RANGE_CHK_EN
        .range_err   (range_err),
`endif
        .donecordic  (donecordic)
    );

    typedef struct {
        logic [31:0] ang;
        logic [31:0] cos_e;
        logic [31:0] sin_e;
    } vec_t;

    vec_t vecs[5];

    // Sign-magnitude word as a signed count of LSBs
    function automatic real sm2fix(input logic [31:0] v);
        real r;
        r = real'(v[30:0]);
        return v[31] ? -r : r;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Within +/-8 LSB of the ideal value, and never a negative zero
    task automatic check_near(input string name, input logic [31:0] got, input real exp_lsb);
        real diff;
        n_cmp++;
        diff = sm2fix(got) - exp_lsb;
        if (diff > 8.0 || diff < -8.0 || got == 32'h8000_0000) begin
            n_err++;
            $display("FAIL %s: got %h (%0.1f lsb) expected %0.1f lsb +/-8", name, got,
                     sm2fix(got), exp_lsb);
        end
    endtask

    // One conversion: start at E0, observe 24 following edges.
    task automatic convert(input logic [31:0] a, input bit pulse_mid, output int done_at,
                           output int done_len, output logic [31:0] c17, output logic [31:0] s17,
                           output logic [31:0] c18, output logic [31:0] s18);
        angle       = a;
        startcordic = 1'b1;
        @(posedge clk);
        #1;
        startcordic = 1'b0;
        angle       = ~a;
        done_at     = 0;
        done_len    = 0;
        c17 = 'x; s17 = 'x; c18 = 'x; s18 = 'x;
        for (int k = 1; k <= 24; k++) begin
            if (pulse_mid && k == 5) startcordic = 1'b1;
            if (pulse_mid && k == 6) startcordic = 1'b0;
            @(posedge clk);
            #1;
            if (donecordic) begin
                if (done_at == 0) done_at = k;
                done_len++;
            end
            if (k == 17) begin c17 = cos_out; s17 = sin_out; end
            if (k == 18) begin c18 = cos_out; s18 = sin_out; end
        end
    endtask

    // Timing checks shared by every conversion
    task automatic check_timing(input string name, input int done_at, input int done_len,
                                input logic [31:0] pc, input logic [31:0] ps,
                                input logic [31:0] c17, input logic [31:0] s17,
                                input logic [31:0] c18, input logic [31:0] s18);
        check_eq({name, "_done_edge"}, 32'(done_at), 32'd19);
        check_eq({name, "_done_len"}, 32'(done_len), 32'd1);
        check_eq({name, "_hold_e17"}, c17 ^ s17, pc ^ ps);
        check_eq({name, "_cos_e18"}, c18, cos_out);
        check_eq({name, "_sin_e18"}, s18, sin_out);
    endtask

    initial begin
        int da, dl;
        logic [31:0] c17, s17, c18, s18, pc, ps;
        logic [31:0] a;
        real ar;

        vecs[0] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
        vecs[1] = '{32'h0001_921F, 32'h0000_0000, 32'h0001_0000};
        vecs[2] = '{32'h0003_243F, 32'h8001_0000, 32'h0000_0000};
        vecs[3] = '{32'h0005_0000, 32'h0000_489E, 32'h8000_F57C};
        vecs[4] = '{32'h8005_0000, 32'h0000_489E, 32'h0000_F57C};

        rst         = 1'b1;
        startcordic = 1'b0;
        angle       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cos", cos_out, 32'h0);
        check_eq("rst_sin", sin_out, 32'h0);
        check_eq("rst_done", 32'(donecordic), 32'h0);
`ifdef CORDIC_RANGE_CHK_EN
        check_eq("rst_range_err", 32'(range_err), 32'h0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            pc = cos_out;
            ps = sin_out;
            convert(vecs[i].ang, 1'b0, da, dl, c17, s17, c18, s18);
            check_timing($sformatf("vec%0d", i), da, dl, pc, ps, c17, s17, c18, s18);
            check_near($sformatf("vec%0d_cos", i), cos_out, sm2fix(vecs[i].cos_e));
            check_near($sformatf("vec%0d_sin", i), sin_out, sm2fix(vecs[i].sin_e));
        end

        // Reset in the middle of the iterations (cnt = 8 after E9)
        angle       = 32'h0005_0000;
        startcordic = 1'b1;
        @(posedge clk);
        #1;
        startcordic = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_eq("midrst_cos", cos_out, 32'h0);
        check_eq("midrst_sin", sin_out, 32'h0);
        check_eq("midrst_done", 32'(donecordic), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Restart after reset with a second start pulse mid-run that must be ignored
        pc = cos_out;
        ps = sin_out;
        convert(32'h0000_0000, 1'b1, da, dl, c17, s17, c18, s18);
        check_timing("ignstart", da, dl, pc, ps, c17, s17, c18, s18);
        check_near("ignstart_cos", cos_out, 65536.0);
        check_near("ignstart_sin", sin_out, 0.0);

        // Random angles over the valid range, both signs
        for (int i = 0; i < 24; i++) begin
            a  = {1'($urandom_range(1, 0)), 31'($urandom_range(32'h0006_487E, 0))};
            ar = sm2fix(a) / 65536.0;
            pc = cos_out;
            ps = sin_out;
            convert(a, 1'b0, da, dl, c17, s17, c18, s18);
            check_timing($sformatf("rnd%0d", i), da, dl, pc, ps, c17, s17, c18, s18);
            check_near($sformatf("rnd%0d_cos(%h)", i, a), cos_out, $cos(ar) * 65536.0);
            check_near($sformatf("rnd%0d_sin(%h)", i, a), sin_out, $sin(ar) * 65536.0);
        end

`ifdef CORDIC_RANGE_CHK_EN
        pc = cos_out;
        ps = sin_out;
        convert(32'h0007_0000, 1'b0, da, dl, c17, s17, c18, s18);
        check_timing("range", da, dl, pc, ps, c17, s17, c18, s18);
        check_eq("range_err_set", 32'(range_err), 32'h1);
        check_eq("range_cos", cos_out, 32'h0001_0000);
        check_eq("range_sin", sin_out, 32'h0);
        convert(32'h0001_921F, 1'b0, da, dl, c17, s17, c18, s18);
        check_eq("range_err_clr", 32'(range_err), 32'h0);
        check_near("range_next_sin", sin_out, 65536.0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
